spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8: SPI frame width in bits; legal 4..16.
REQ-002 Parameter NUM_SS, default 4: number of slave-select lines; legal 1..8.
REQ-003 Parameter FIFO_DEPTH, default 8: entries in each of the TX and RX FIFOs; power of two, 2..32.
REQ-004 PCLK input 1: sole clock; all state changes on its rising edge.
REQ-005 PRESET input 1: reset, asynchronous and active-high.
REQ-006 PSEL, PENABLE, PWRITE inputs 1 each: APB control.
REQ-007 PADDR input 3: register word address.
REQ-008 PWDATA input 16: write data.
REQ-009 PRDATA output 16: read data.
REQ-010 PREADY output 1: always 1 (zero wait state).
REQ-011 PSLVERR output 1: error response, valid in the access phase.
REQ-012 sclk output 1: serial clock.
REQ-013 mosi output 1: serial data out.
REQ-014 miso input 1: serial data in; sampled without a synchroniser.
REQ-015 ss_n output NUM_SS: active-low slave selects.
REQ-016 spi_interrupt_request output 1: level interrupt.

Function
REQ-017 Register map (PADDR): 0 CTRL RW; 1 BAUD RW; 2 SSSEL RW; 3 STATUS RO except W1C bits; 4 TXDATA WO; 5 RXDATA RO; 6-7 reserved.
REQ-018 CTRL bits: 0 SPE enable, 1 CPOL, 2 CPHA, 3 LSBFE, 4 CONT (hold ss between frames), 5 TXEIE, 6 RXNEIE, 7 OVRIE.
REQ-019 BAUD[7:0] = N; each sclk half-period lasts N+1 PCLK cycles.
REQ-020 SSSEL[2:0] selects the ss_n line; values >= NUM_SS select none, and no frame starts.
REQ-021 STATUS bits: 0 TXE, 1 TXF, 2 RXNE, 3 RXF, 4 BUSY, 5 RXOVR (W1C), 6 TXERR (W1C).
REQ-022 An APB write or read takes effect on the access phase (PSEL & PENABLE); reads return zero-extended data.
REQ-023 PSLVERR = 1 for: reserved-address access; write to STATUS bits other than 5-6; write to RXDATA; TXDATA write when TX full (data dropped, TXERR set); RXDATA read when RX empty (returns 0).
REQ-024 CTRL, BAUD and SSSEL writes are ignored (with PSLVERR) while BUSY=1.
REQ-025 FSM states: IDLE, SETUP, SHIFT, HOLD.
REQ-026 IDLE -> SETUP when SPE=1, TX FIFO is non-empty and SSSEL is valid; pop one word, assert the selected ss_n.
REQ-027 SETUP lasts one half-period; with CPHA=0, drive the first bit on mosi on entry.
REQ-028 SHIFT runs 2*DATA_W half-periods; sclk toggles at each half-period boundary starting from CPOL.
REQ-029 The leading edge samples with CPHA=0 and shifts with CPHA=1; the trailing edge does the opposite.
REQ-030 Bit order is MSB-first when LSBFE=0 and LSB-first when LSBFE=1.
REQ-031 After the last edge go to HOLD for one half-period and push the received word into the RX FIFO.
REQ-032 If RX is full at that push, drop the word and set RXOVR.
REQ-033 HOLD -> SETUP (pop next word) if CONT=1 and TX is non-empty; ss_n stays low.
REQ-034 Otherwise HOLD -> IDLE and deassert ss_n.
REQ-035 Clearing SPE mid-frame: finish the current frame, then go to IDLE.
REQ-036 BUSY = (state != IDLE).
REQ-037 A simultaneous APB TXDATA push and FSM pop on a full FIFO succeeds (pop first); same rule for a RXDATA pop and FSM push on RX.
REQ-038 spi_interrupt_request = (TXEIE & TXE) | (RXNEIE & RXNE) | (OVRIE & RXOVR), registered.
REQ-039 mosi = 0 and sclk = CPOL whenever in IDLE.

Reset
REQ-040 On PRESET: CTRL=0, BAUD=0, SSSEL=0, both FIFOs empty, RXOVR=TXERR=0, FSM=IDLE, sclk=0, mosi=0, ss_n all 1, PRDATA=0, PSLVERR=0, spi_interrupt_request=0.
REQ-041 Reset during a frame aborts it immediately; no partial word enters the RX FIFO.

Structure
REQ-042 Package spi_multi_pkg holds: register address constants, CTRL/STATUS bit indices, and the FSM state enum.
REQ-043 One sub-module, spi_sync_fifo (parameterised width and depth, with full/empty flags), is instantiated for TX and for RX.

Verification
REQ-044 DATA_W=8, BAUD=1, mode 0, SSSEL=0; write 0xA5; miso loopback -> sclk period 4 PCLK; mosi 1,0,1,0,0,1,0,1; RXDATA=0xA5; ss_n=4'b1110 only during the frame.
REQ-045 Modes 1-3 with 0x3C and LSBFE=1 -> mosi 0,0,1,1,1,1,0,0; sample and shift edges match REQ-029; idle sclk equals CPOL.
REQ-046 CONT=1; push 3 words -> ss_n low continuously across 3 frames; RX holds 3 words in order.
REQ-047 Push FIFO_DEPTH+1 words with SPE=0 -> last write gives PSLVERR=1 and TXERR=1; TXF=1.
REQ-048 FIFO_DEPTH+1 frames without reading RX -> RXOVR=1 and irq with OVRIE; an RXDATA read while empty returns 0 with PSLVERR=1.
REQ-049 Assert PRESET mid-SHIFT -> all outputs at reset values in the same cycle; RXNE=0 after release.

Source files
------------

// File: rtl/spi_multi_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state encoding
// for the multi-slave SPI master.
package spi_multi_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_BAUD   = 3'd1;
   localparam logic [2:0] ADDR_SSSEL  = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_TXDATA = 3'd4;
   localparam logic [2:0] ADDR_RXDATA = 3'd5;

   localparam int unsigned CTRL_SPE    = 0;
   localparam int unsigned CTRL_CPOL   = 1;
   localparam int unsigned CTRL_CPHA   = 2;
   localparam int unsigned CTRL_LSBFE  = 3;
   localparam int unsigned CTRL_CONT   = 4;
   localparam int unsigned CTRL_TXEIE  = 5;
   localparam int unsigned CTRL_RXNEIE = 6;
   localparam int unsigned CTRL_OVRIE  = 7;

   localparam int unsigned ST_TXE   = 0;
   localparam int unsigned ST_TXF   = 1;
   localparam int unsigned ST_RXNE  = 2;
   localparam int unsigned ST_RXF   = 3;
   localparam int unsigned ST_BUSY  = 4;
   localparam int unsigned ST_RXOVR = 5;
   localparam int unsigned ST_TXERR = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD
   } spi_state_t;

endpackage

// File: rtl/spi_multi_fifo.sv
// Show-ahead synchronous FIFO; a pop frees space for a push in the same cycle.
module spi_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/spi_master_multi.sv
// APB-programmed SPI master with TX/RX FIFOs, selectable slave line,
// all four clock modes and optional continuous slave select.
module spi_master_multi
   import spi_multi_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_SS     = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [2:0]        PADDR,
   input  logic [15:0]       PWDATA,
   output logic [15:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n,
   output logic              spi_interrupt_request
);

   localparam int unsigned EW = $clog2(2*DATA_W);

   logic [7:0]        ctrl, baud;
   logic [2:0]        sssel;
   logic              rxovr, txerr, irq_r;
   spi_state_t        state, state_nxt;
   logic [7:0]        div_cnt;
   logic [EW-1:0]     edge_cnt;
   logic [DATA_W-1:0] tx_sr, rx_sr, tx_word, rx_word;
   logic              sclk_r, mosi_r;
   logic [NUM_SS-1:0] ss_r;
   logic              tx_push, tx_pop, tx_full, tx_empty, tx_drop;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_W-1:0] tx_rdata, rx_rdata;
   logic              load, tick, last_edge, busy, sssel_ok, access, wr;
   logic              spe, cpol, cpha, lsbfe, cont;
   logic [15:0]       status;

   function automatic logic [DATA_W-1:0] bit_order(input logic [DATA_W-1:0] w, input logic lsb);
      logic [DATA_W-1:0] r;
      for (int unsigned i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
      return lsb ? r : w;
   endfunction

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [2:0] sel);
      logic [NUM_SS-1:0] r;
      r = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) if (32'(sel) == i) r[i] = 1'b0;
      return r;
   endfunction

   assign spe       = ctrl[CTRL_SPE];
   assign cpol      = ctrl[CTRL_CPOL];
   assign cpha      = ctrl[CTRL_CPHA];
   assign lsbfe     = ctrl[CTRL_LSBFE];
   assign cont      = ctrl[CTRL_CONT];
   assign busy      = (state != S_IDLE);
   assign sssel_ok  = (32'(sssel) < NUM_SS);
   assign tick      = (div_cnt == baud);
   assign last_edge = (edge_cnt == EW'(2*DATA_W-1));
   // Shifting is always MSB-first internally; LSB-first frames are reversed at load/unload.
   assign tx_word   = bit_order(tx_rdata, lsbfe);
   assign rx_word   = bit_order(rx_sr, lsbfe);
   assign status    = {9'b0, txerr, rxovr, busy, rx_full, ~rx_empty, tx_full, tx_empty};
   assign access    = PSEL & PENABLE;
   assign wr        = access & PWRITE;
   assign PREADY    = 1'b1;
   assign sclk      = (state == S_IDLE) ? cpol : sclk_r;
   assign mosi      = (state == S_IDLE) ? 1'b0 : mosi_r;
   assign ss_n      = ss_r;
   assign spi_interrupt_request = irq_r;

   spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(PCLK), .rst(PRESET), .push(tx_push), .wdata(PWDATA[DATA_W-1:0]),
      .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
   );

   spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(PCLK), .rst(PRESET), .push(rx_push), .wdata(rx_word),
      .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      load      = 1'b0;
      rx_push   = 1'b0;
      case (state)
         S_IDLE: if (spe && !tx_empty && sssel_ok) begin
            state_nxt = S_SETUP;
            tx_pop    = 1'b1;
            load      = 1'b1;
         end
         S_SETUP: if (tick) state_nxt = S_SHIFT;
         S_SHIFT: if (tick && last_edge) state_nxt = S_HOLD;
         S_HOLD: begin
            rx_push = (div_cnt == '0);
            if (tick) begin
               if (spe && cont && !tx_empty) begin
                  state_nxt = S_SETUP;
                  tx_pop    = 1'b1;
                  load      = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         sclk_r   <= 1'b0;
         mosi_r   <= 1'b0;
         ss_r     <= '1;
      end else begin
         if (state == S_IDLE || tick) div_cnt <= '0;
         else                         div_cnt <= div_cnt + 8'd1;
         if (load) begin
            edge_cnt <= '0;
            sclk_r   <= cpol;
            ss_r     <= ss_decode(sssel);
            if (!cpha) begin
               mosi_r <= tx_word[DATA_W-1];
               tx_sr  <= tx_word << 1;
            end else begin
               tx_sr  <= tx_word;
            end
         end else if (state == S_SHIFT && tick) begin
            sclk_r   <= ~sclk_r;
            edge_cnt <= edge_cnt + EW'(1);
            // Even edges are leading: they sample when CPHA=0, shift when CPHA=1.
            if (edge_cnt[0] == cpha) begin
               rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else begin
               mosi_r <= tx_sr[DATA_W-1];
               tx_sr  <= tx_sr << 1;
            end
         end else if (state == S_HOLD && tick) begin
            ss_r <= '1;
         end else if (state == S_IDLE) begin
            mosi_r <= 1'b0;
         end
      end
   end

   always_comb begin
      PRDATA  = '0;
      PSLVERR = 1'b0;
      tx_push = 1'b0;
      tx_drop = 1'b0;
      rx_pop  = 1'b0;
      if (access) begin
         case (PADDR)
            ADDR_CTRL:   if (PWRITE) PSLVERR = busy; else PRDATA = {8'h00, ctrl};
            ADDR_BAUD:   if (PWRITE) PSLVERR = busy; else PRDATA = {8'h00, baud};
            ADDR_SSSEL:  if (PWRITE) PSLVERR = busy; else PRDATA = {13'h0000, sssel};
            ADDR_STATUS: if (PWRITE) PSLVERR = |(PWDATA & ~16'h0060); else PRDATA = status;
            ADDR_TXDATA: if (PWRITE) begin
               tx_drop = tx_full & ~tx_pop;
               tx_push = ~tx_drop;
               PSLVERR = tx_drop;
            end
            ADDR_RXDATA: if (PWRITE || rx_empty) begin
               PSLVERR = 1'b1;
            end else begin
               PRDATA = 16'(rx_rdata);
               rx_pop = 1'b1;
            end
            default: PSLVERR = 1'b1;
         endcase
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ctrl  <= '0;
         baud  <= '0;
         sssel <= '0;
         rxovr <= 1'b0;
         txerr <= 1'b0;
         irq_r <= 1'b0;
      end else begin
         if (wr && !busy) begin
            case (PADDR)
               ADDR_CTRL:  ctrl  <= PWDATA[7:0];
               ADDR_BAUD:  baud  <= PWDATA[7:0];
               ADDR_SSSEL: sssel <= PWDATA[2:0];
               default: ;
            endcase
         end
         if (rx_push && rx_full && !rx_pop)                         rxovr <= 1'b1;
         else if (wr && PADDR == ADDR_STATUS && PWDATA[ST_RXOVR])   rxovr <= 1'b0;
         if (tx_drop)                                               txerr <= 1'b1;
         else if (wr && PADDR == ADDR_STATUS && PWDATA[ST_TXERR])   txerr <= 1'b0;
         irq_r <= (ctrl[CTRL_TXEIE] & tx_empty) | (ctrl[CTRL_RXNEIE] & ~rx_empty)
                | (ctrl[CTRL_OVRIE] & rxovr);
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: mosi looped back to miso, frames
// observed at the pins and read back through APB.
module tb_spi_master_multi;
   import spi_multi_pkg::*;

   localparam int unsigned DW  = 8;
   localparam int unsigned NSS = 4;
   localparam int unsigned FD  = 8;

   logic           PCLK = 1'b0;
   logic           PRESET, PSEL, PENABLE, PWRITE;
   logic [2:0]     PADDR;
   logic [15:0]    PWDATA, PRDATA;
   logic           PREADY, PSLVERR, sclk, mosi, miso, irq;
   logic [NSS-1:0] ss_n;
   int             errors = 0;
   int             checks = 0;

   always #5 PCLK = ~PCLK;
   assign miso = mosi;

   spi_master_multi #(.DATA_W(DW), .NUM_SS(NSS), .FIFO_DEPTH(FD)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n), .spi_interrupt_request(irq)
   );

   task automatic apb_write(input logic [2:0] a, input logic [15:0] d, output logic err);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      #3 err = PSLVERR;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] a, output logic [15:0] d, output logic err);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      #3 d = PRDATA; err = PSLVERR;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // Watches one ss_n-low interval; records mosi at slave sample edges.
   task automatic capture_frame(input logic cpol, input logic cpha, input logic [NSS-1:0] ss_exp,
                                output logic [47:0] cap, output int edges, output int period,
                                output int bad_ss, output bit to);
      int  cyc, e0, e2;
      bit  started;
      logic prev;
      cap = '0; edges = 0; bad_ss = 0; to = 1'b1; started = 1'b0;
      cyc = 0; e0 = 0; e2 = 0; prev = sclk;
      while (cyc < 2000) begin
         @(negedge PCLK); cyc++;
         if (ss_n !== '1) begin
            started = 1'b1;
            if (ss_n !== ss_exp) bad_ss++;
         end else if (started) begin
            to = 1'b0;
            break;
         end
         if (sclk !== prev) begin
            if (edges == 0) e0 = cyc;
            if (edges == 2) e2 = cyc;
            if ((prev == cpol) != cpha) cap = {cap[46:0], mosi};
            edges++;
         end
         prev = sclk;
      end
      period = e2 - e0;
   endtask

   task automatic test_reset();
      logic [15:0] d; logic e;
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(posedge PCLK); #1;
      checks++; if ({sclk, mosi, ss_n, irq, PSLVERR, PREADY, PRDATA} !== {1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 16'h0}) begin
         errors++; $display("FAIL reset_outputs: got %b expected %b", {sclk, mosi, ss_n, irq, PSLVERR, PREADY, PRDATA}, {1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 16'h0}); end
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      apb_read(ADDR_STATUS, d, e);
      checks++; if ({e, d} !== {1'b0, 16'h0001}) begin
         errors++; $display("FAIL reset_status: got err=%b data=%h expected err=0 data=0001", e, d); end
      apb_read(ADDR_CTRL, d, e);
      checks++; if ({e, d} !== {1'b0, 16'h0000}) begin
         errors++; $display("FAIL reset_ctrl: got err=%b data=%h expected err=0 data=0000", e, d); end
   endtask

   task automatic test_irq_txe();
      logic e;
      apb_write(ADDR_CTRL, 16'h0020, e);
      repeat (2) @(posedge PCLK); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_txe_on: got %b expected 1", irq); end
      apb_write(ADDR_CTRL, 16'h0000, e);
      repeat (2) @(posedge PCLK); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_txe_off: got %b expected 0", irq); end
   endtask

   task automatic test_mode0();
      logic [15:0] d; logic e; logic [47:0] cap; int edges, period, bad_ss; bit to;
      apb_write(ADDR_BAUD, 16'h0001, e);
      apb_write(ADDR_SSSEL, 16'h0000, e);
      apb_write(ADDR_CTRL, 16'h0001, e);
      apb_write(ADDR_TXDATA, 16'h00A5, e);
      capture_frame(1'b0, 1'b0, 4'b1110, cap, edges, period, bad_ss, to);
      checks++; if (to) begin errors++; $display("FAIL mode0_timeout: frame did not end"); end
      checks++; if (cap[7:0] !== 8'hA5) begin errors++; $display("FAIL mode0_mosi: got %h expected a5", cap[7:0]); end
      checks++; if (edges !== 16) begin errors++; $display("FAIL mode0_edges: got %0d expected 16", edges); end
      checks++; if (period !== 4) begin errors++; $display("FAIL mode0_period: got %0d expected 4", period); end
      checks++; if (bad_ss !== 0) begin errors++; $display("FAIL mode0_ss: got %0d wrong samples expected 0", bad_ss); end
      apb_read(ADDR_RXDATA, d, e);
      checks++; if ({e, d} !== {1'b0, 16'h00A5}) begin
         errors++; $display("FAIL mode0_rx: got err=%b data=%h expected err=0 data=00a5", e, d); end
   endtask

   task automatic test_modes();
      logic [15:0] d; logic e; logic [47:0] cap; int edges, period, bad_ss; bit to;
      logic cpol, cpha;
      for (int m = 1; m <= 3; m++) begin
         cpol = m[1]; cpha = m[0];
         apb_write(ADDR_CTRL, {12'h000, 1'b1, cpha, cpol, 1'b1}, e);
         checks++; if (sclk !== cpol) begin errors++; $display("FAIL mode%0d_idle_sclk: got %b expected %b", m, sclk, cpol); end
         apb_write(ADDR_TXDATA, 16'h003C, e);
         capture_frame(cpol, cpha, 4'b1110, cap, edges, period, bad_ss, to);
         checks++; if (to || cap[7:0] !== 8'h3C || edges !== 16) begin
            errors++; $display("FAIL mode%0d_frame: got to=%b bits=%h edges=%0d expected to=0 bits=3c edges=16", m, to, cap[7:0], edges); end
         apb_read(ADDR_RXDATA, d, e);
         checks++; if ({e, d} !== {1'b0, 16'h003C}) begin
            errors++; $display("FAIL mode%0d_rx: got err=%b data=%h expected err=0 data=003c", m, e, d); end
         checks++; if (sclk !== cpol) begin errors++; $display("FAIL mode%0d_end_sclk: got %b expected %b", m, sclk, cpol); end
      end
   endtask

   task automatic test_lsb_first();
      logic [15:0] d; logic e; logic [47:0] cap; int edges, period, bad_ss; bit to;
      apb_write(ADDR_CTRL, 16'h0009, e);
      apb_write(ADDR_TXDATA, 16'h0001, e);
      capture_frame(1'b0, 1'b0, 4'b1110, cap, edges, period, bad_ss, to);
      checks++; if (to || cap[7:0] !== 8'h80) begin
         errors++; $display("FAIL lsb_mosi: got to=%b bits=%h expected to=0 bits=80", to, cap[7:0]); end
      apb_read(ADDR_RXDATA, d, e);
      checks++; if ({e, d} !== {1'b0, 16'h0001}) begin
         errors++; $display("FAIL lsb_rx: got err=%b data=%h expected err=0 data=0001", e, d); end
   endtask

   task automatic test_sssel();
      logic [15:0] d; logic e; logic [47:0] cap; int edges, period, bad_ss; bit to; int ss_seen;
      apb_write(ADDR_CTRL, 16'h0000, e);
      apb_write(ADDR_SSSEL, 16'h0004, e);
      apb_write(ADDR_CTRL, 16'h0001, e);
      apb_write(ADDR_TXDATA, 16'h005A, e);
      ss_seen = 0;
      repeat (30) begin @(negedge PCLK); if (ss_n !== 4'hF) ss_seen++; end
      checks++; if (ss_seen !== 0) begin errors++; $display("FAIL sssel_invalid_ss: got %0d low samples expected 0", ss_seen); end
      apb_read(ADDR_STATUS, d, e);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sssel_invalid_status: got %h expected 0000", d); end
      apb_write(ADDR_SSSEL, 16'h0002, e);
      capture_frame(1'b0, 1'b0, 4'b1011, cap, edges, period, bad_ss, to);
      checks++; if (to || bad_ss !== 0 || cap[7:0] !== 8'h5A) begin
         errors++; $display("FAIL sssel2_frame: got to=%b bad_ss=%0d bits=%h expected to=0 bad_ss=0 bits=5a", to, bad_ss, cap[7:0]); end
      apb_read(ADDR_RXDATA, d, e);
      checks++; if ({e, d} !== {1'b0, 16'h005A}) begin
         errors++; $display("FAIL sssel2_rx: got err=%b data=%h expected err=0 data=005a", e, d); end
      apb_write(ADDR_SSSEL, 16'h0000, e);
   endtask

   task automatic test_back_to_back();
      logic [15:0] d; logic e; logic [47:0] cap; int edges, period, bad_ss; bit to;
      logic [15:0] exp_w [3];
      exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033;
      apb_write(ADDR_CTRL, 16'h0000, e);
      for (int i = 0; i < 3; i++) apb_write(ADDR_TXDATA, exp_w[i], e);
      apb_write(ADDR_CTRL, 16'h0011, e);
      capture_frame(1'b0, 1'b0, 4'b1110, cap, edges, period, bad_ss, to);
      checks++; if (to || edges !== 48 || bad_ss !== 0) begin
         errors++; $display("FAIL cont_ss: got to=%b edges=%0d bad_ss=%0d expected to=0 edges=48 bad_ss=0", to, edges, bad_ss); end
      checks++; if (cap[23:0] !== 24'h112233) begin
         errors++; $display("FAIL cont_mosi: got %h expected 112233", cap[23:0]); end
      for (int i = 0; i < 3; i++) begin
         apb_read(ADDR_RXDATA, d, e);
         checks++; if ({e, d} !== {1'b0, exp_w[i]}) begin
            errors++; $display("FAIL cont_rx%0d: got err=%b data=%h expected err=0 data=%h", i, e, d, exp_w[i]); end
      end
   endtask

   task automatic test_tx_overflow();
      logic [15:0] d; logic e; int nerr;
      apb_write(ADDR_CTRL, 16'h0000, e);
      nerr = 0;
      for (int i = 0; i < FD; i++) begin
         apb_write(ADDR_TXDATA, 16'h0010 + 16'(i), e);
         if (e !== 1'b0) nerr++;
      end
      checks++; if (nerr !== 0) begin errors++; $display("FAIL txfill_err: got %0d errors expected 0", nerr); end
      apb_write(ADDR_TXDATA, 16'h0099, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL txovf_pslverr: got %b expected 1", e); end
      apb_read(ADDR_STATUS, d, e);
      checks++; if (d !== 16'h0042) begin errors++; $display("FAIL txovf_status: got %h expected 0042", d); end
      apb_write(ADDR_STATUS, 16'h0040, e);
      apb_read(ADDR_STATUS, d, e);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL txerr_w1c: got %h expected 0002", d); end
      apb_write(ADDR_STATUS, 16'h0001, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL status_ro_write: got %b expected 1", e); end
      apb_read(3'd6, d, e);
      checks++; if ({e, d} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL reserved_read: got err=%b data=%h expected err=1 data=0000", e, d); end
      apb_write(ADDR_RXDATA, 16'h0001, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL rxdata_write: got %b expected 1", e); end
   endtask

   task automatic test_rx_overflow();
      logic [15:0] d; logic e; int polls;
      apb_write(ADDR_BAUD, 16'h0000, e);
      apb_write(ADDR_CTRL, 16'h0081, e);
      polls = 0; d = '0;
      while (d[ST_BUSY] !== 1'b1 && polls < 50) begin apb_read(ADDR_STATUS, d, e); polls++; end
      checks++; if (d[ST_BUSY] !== 1'b1) begin errors++; $display("FAIL rxovf_start: got busy=%b expected 1", d[ST_BUSY]); end
      apb_write(ADDR_BAUD, 16'h0005, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b expected 1", e); end
      apb_read(ADDR_BAUD, d, e);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL busy_write_ignored: got %h expected 0000", d); end
      apb_write(ADDR_TXDATA, 16'h0077, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL push_ninth: got %b expected 0", e); end
      polls = 0; d = '0;
      while (!(d[ST_TXE] === 1'b1 && d[ST_BUSY] === 1'b0) && polls < 1000) begin apb_read(ADDR_STATUS, d, e); polls++; end
      checks++; if (d !== 16'h002D) begin errors++; $display("FAIL rxovf_status: got %h expected 002d", d); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rxovf_irq: got %b expected 1", irq); end
      for (int i = 0; i < FD; i++) begin
         apb_read(ADDR_RXDATA, d, e);
         checks++; if ({e, d} !== {1'b0, 16'h0010 + 16'(i)}) begin
            errors++; $display("FAIL rx_order%0d: got err=%b data=%h expected err=0 data=%h", i, e, d, 16'h0010 + 16'(i)); end
      end
      apb_read(ADDR_RXDATA, d, e);
      checks++; if ({e, d} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL rx_empty_read: got err=%b data=%h expected err=1 data=0000", e, d); end
      apb_write(ADDR_STATUS, 16'h0020, e);
      repeat (2) @(posedge PCLK); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rxovr_clear_irq: got %b expected 0", irq); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d; logic e; int edges, cyc; logic prev;
      apb_write(ADDR_BAUD, 16'h0003, e);
      apb_write(ADDR_CTRL, 16'h0003, e);
      apb_write(ADDR_TXDATA, 16'h00C3, e);
      edges = 0; cyc = 0; prev = sclk;
      while (edges < 3 && cyc < 500) begin
         @(negedge PCLK); cyc++;
         if (sclk !== prev) edges++;
         prev = sclk;
      end
      checks++; if (edges < 3) begin errors++; $display("FAIL midreset_shift: got %0d edges expected 3", edges); end
      PRESET = 1'b1;
      #1;
      checks++; if ({sclk, mosi, ss_n, irq, PSLVERR, PRDATA} !== {1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 16'h0}) begin
         errors++; $display("FAIL midreset_outputs: got %b expected %b", {sclk, mosi, ss_n, irq, PSLVERR, PRDATA}, {1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 16'h0}); end
      repeat (2) @(posedge PCLK); #1 PRESET = 1'b0;
      @(posedge PCLK); #1;
      apb_read(ADDR_STATUS, d, e);
      checks++; if (d !== 16'h0001) begin errors++; $display("FAIL midreset_status: got %h expected 0001", d); end
   endtask

   initial begin
      test_reset();
      test_irq_txe();
      test_mode0();
      test_modes();
      test_lsb_first();
      test_sssel();
      test_back_to_back();
      test_tx_overflow();
      test_rx_overflow();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
